counter_8bit: RTL and testbench
===============================

// Module: counter_8bit
// PURPOSE
//  8-bit up/down counter for board display. Advances once per TICK_HZ period
//  derived from the 50 MHz board clock. Run/pause and direction come from
//  slide switches; the count value drives LEDs or a 7-seg decoder downstream.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency
//  TICK_HZ  1           count rate; DIV = CLK_HZ/TICK_HZ (>=2), sims override CLK_HZ=4
//  WIDTH    8           count width; dem8_bit width tracks it
// PORTS
//  clk50m    in   1      system clock, 50 MHz, all logic on rising edge
//  rs        in   1      reset, asynchronous assert, active-low (0 = reset)
//  ss        in   1      start/stop: 0 = run, 1 = pause (async switch)
//  ud        in   1      direction: 1 = up, 0 = down (async switch)
//  dem8_bit  out  WIDTH  current count, registered
// BEHAVIOUR
//  - Reset (rs=0, async): dem8_bit=0, prescaler=0, synchronizer flops=0 (run, down).
//    Deassert rs synchronously: 2-flop reset synchronizer, release on 2nd edge.
//  - ss and ud each pass a 2-flop synchronizer; internal ss_s/ud_s lag pins by 2 clocks.
//  - Prescaler: counts 0..DIV-1 while ss_s=0, wraps to 0; tick=1 for one clock
//    when prescaler==DIV-1 and ss_s=0.
//  - ss_s=1: prescaler and count hold (phase preserved); resume continues from held phase.
//  - On tick: ud_s=1 -> count+1, ud_s=0 -> count-1, modulo 2^WIDTH.
//    Wrap: 255 up -> 0; 0 down -> 255. No saturation, no carry output.
//  - ud change only affects the next tick; never causes an extra or skipped step.
//  - Latency: first change of dem8_bit occurs DIV clocks after internal reset release
//    (ss held 0). Steady state: one step every DIV clocks exactly.
//  - Reset mid-count: dem8_bit to 0 immediately (async), prescaler restarts at 0.
//  - ss and ud toggled same clock: both take effect together after sync latency.
// STRUCTURE
//  - Shared package: CLK_HZ default, DIV computation function, count width constant.
//  - Sub-module tick_gen (prescaler + synchronizers -> tick, ud_s); top holds
//    the up/down count register. No FSM required.
// TESTING (CLK_HZ=4, TICK_HZ=1 -> DIV=4; clock period 20 ns)
//  1. rs=0 20 ns, ss=0, ud=1 -> dem8_bit=0 during reset; then 1,2,3 every 4 clocks.
//  2. Count up from 254 -> 255 -> 0 (wrap); ud=0 at 1 -> 0 -> 255 -> 254.
//  3. ss=1 while count=5 -> holds 5 for 40 clocks; ss=0 -> 6 after remaining phase.
//  4. Flip ud between ticks at count 10 -> next step 9, no double step or glitch.
//  5. rs pulse low mid-count at 77 -> dem8_bit=0 within same clock, no clk edge needed.
//  6. ss glitch shorter than 1 clock -> no effect on count (sync filters or delays).

Source files
------------

// File: rtl/counter_8bit_pkg.sv
// Shared constants and helpers for the board-display up/down counter.
//   CLK_HZ_DEFAULT  : board clock frequency (50 MHz)
//   TICK_HZ_DEFAULT : default count rate (1 Hz)
//   WIDTH_DEFAULT   : default count width (8 bits)
//   calc_div()      : clocks per count step, clamped to a minimum of 2
package counter_8bit_pkg;

    localparam int unsigned CLK_HZ_DEFAULT  = 50_000_000;
    localparam int unsigned TICK_HZ_DEFAULT = 1;
    localparam int unsigned WIDTH_DEFAULT   = 8;

    // A divide ratio below 2 would leave the prescaler with no range to count
    // through, so it is clamped to 2.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        int unsigned d;
        d = clk_hz / tick_hz;
        return (d < 2) ? 2 : d;
    endfunction

endpackage

// File: rtl/counter_8bit_tick_gen.sv
// Step-timing front end for counter_8bit.
//   clk_i  : system clock, rising edge
//   rst_ni : reset, asynchronous assert, active-low
//   ss_i   : start/stop switch (0 = run, 1 = pause), asynchronous to clk_i
//   ud_i   : direction switch (1 = up, 0 = down), asynchronous to clk_i
//   tick_o : one-clock pulse when the counter should step
//   ud_s_o : synchronised direction switch
// The reset is asserted immediately but released through two flops. Both
// switches pass through their own 2-flop synchronisers. While the design is
// running, the prescaler counts 0..DIV-1.
module counter_8bit_tick_gen
    import counter_8bit_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ss_i,
    input  logic ud_i,
    output logic tick_o,
    output logic ud_s_o
);

    localparam int unsigned   PW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [1:0]    rst_sync_q;
    logic [1:0]    ss_sync_q;
    logic [1:0]    ud_sync_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          run_en;

    // The prescaler only advances once the internal reset has been released
    // and the pause switch, after synchronisation, reads "run". A pause
    // freezes the prescaler in place, so the phase is preserved across it.
    assign run_en = rst_sync_q[1] & ~ss_sync_q[1];
    assign tick_o = run_en & (presc_q == LAST);
    assign ud_s_o = ud_sync_q[1];

    always_comb begin
        presc_d = presc_q;
        if (run_en) begin
            presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= '0;
            ss_sync_q  <= '0;
            ud_sync_q  <= '0;
            presc_q    <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
            ss_sync_q  <= {ss_sync_q[0], ss_i};
            ud_sync_q  <= {ud_sync_q[0], ud_i};
            presc_q    <= presc_d;
        end
    end

endmodule

// File: rtl/counter_8bit.sv
// 8-bit up/down display counter that steps once per TICK_HZ period.
//   clk50m   : system clock, 50 MHz, rising edge
//   rs       : reset, asynchronous assert, active-low
//   ss       : start/stop switch (0 = run, 1 = pause)
//   ud       : direction switch (1 = up, 0 = down)
//   dem8_bit : current count, registered
// On reset the count clears to 0 at once, without waiting for a clock edge.
// On a tick it steps up or down, modulo 2^WIDTH.
module counter_8bit
    import counter_8bit_pkg::*;
#(
    parameter int unsigned CLK_HZ  = CLK_HZ_DEFAULT,
    parameter int unsigned TICK_HZ = TICK_HZ_DEFAULT,
    parameter int unsigned WIDTH   = WIDTH_DEFAULT
) (
    input  logic             clk50m,
    input  logic             rs,
    input  logic             ss,
    input  logic             ud,
    output logic [WIDTH-1:0] dem8_bit
);

    localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);

    logic             tick;
    logic             ud_s;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    counter_8bit_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk_i  (clk50m),
        .rst_ni (rs),
        .ss_i   (ss),
        .ud_i   (ud),
        .tick_o (tick),
        .ud_s_o (ud_s)
    );

    // The count wraps naturally through the fixed-width add and subtract.
    always_comb begin
        count_d = count_q;
        if (tick) begin
            count_d = ud_s ? count_q + 1'b1 : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk50m or negedge rs) begin
        if (!rs) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign dem8_bit = count_q;

endmodule

// File: tb/tb_counter_8bit.sv
module tb_counter_8bit;

    logic       clk50m = 1'b0;
    logic       rs     = 1'b1;
    logic       ss     = 1'b0;
    logic       ud     = 1'b1;
    logic [7:0] dem8_bit;

    typedef struct {
        logic [7:0] val;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    counter_8bit #(
        .CLK_HZ  (4),
        .TICK_HZ (1),
        .WIDTH   (8)
    ) dut (
        .clk50m   (clk50m),
        .rs       (rs),
        .ss       (ss),
        .ud       (ud),
        .dem8_bit (dem8_bit)
    );

    always #10 clk50m = ~clk50m;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push_step(input logic [7:0] v, input int g);
        exp_t e;
        e.val = v;
        e.gap = g;
        exp_q.push_back(e);
    endtask

    // Waits for the next change of dem8_bit, counting falling edges. The wait
    // is bounded: on a timeout the gap reads 64 and no longer matches.
    task automatic wait_change(output logic [7:0] v, output int n);
        logic [7:0] prev;
        prev = dem8_bit;
        n = 0;
        do begin
            @(negedge clk50m);
            n++;
        end while (dem8_bit === prev && n < 64);
        v = dem8_bit;
    endtask

    task automatic test_reset();
        exp_t       e;
        logic [7:0] got;
        int         n;
        #1 rs = 1'b0;
        #14;
        vectors++;
        if (dem8_bit !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_value got %0d want 0", dem8_bit);
        end else $display("reset_value %0d", dem8_bit);
        @(negedge clk50m);
        @(negedge clk50m);
        rs = 1'b1;
        // Two sync edges, then DIV clocks, give the first step.
        push_step(8'd1, 6);
        push_step(8'd2, 4);
        push_step(8'd3, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_change(got, n);
            vectors++;
            if (got !== e.val || n != e.gap) begin
                miscompares++;
                $display("FAIL reset_count got %0d after %0d clk want %0d after %0d clk", got, n, e.val, e.gap);
            end else $display("reset_count %0d after %0d clk", got, n);
        end
    endtask

    task automatic test_wrap();
        exp_t       e;
        logic [7:0] got;
        int         n;
        ud = 1'b0;
        push_step(8'd2, 4); push_step(8'd1, 4); push_step(8'd0, 4);
        push_step(8'd255, 4); push_step(8'd254, 4);
        for (int phase = 0; phase < 3; phase++) begin
            if (phase == 1) begin
                ud = 1'b1;
                push_step(8'd255, 4); push_step(8'd0, 4); push_step(8'd1, 4);
            end else if (phase == 2) begin
                ud = 1'b0;
                push_step(8'd0, 4); push_step(8'd255, 4); push_step(8'd254, 4);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                wait_change(got, n);
                vectors++;
                if (got !== e.val || n != e.gap) begin
                    miscompares++;
                    $display("FAIL wrap got %0d after %0d clk want %0d after %0d clk", got, n, e.val, e.gap);
                end else $display("wrap %0d after %0d clk", got, n);
            end
        end
    endtask

    task automatic test_pause();
        exp_t       e;
        logic [7:0] got;
        int         n;
        bit         held;
        ud = 1'b1;
        push_step(8'd255, 4); push_step(8'd0, 4); push_step(8'd1, 4);
        push_step(8'd2, 4); push_step(8'd3, 4); push_step(8'd4, 4);
        push_step(8'd5, 4);
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) begin
                ss = 1'b1;
                held = 1'b1;
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk50m);
                    if (dem8_bit !== 8'd5) held = 1'b0;
                end
                vectors++;
                if (!held || dem8_bit !== 8'd5) begin
                    miscompares++;
                    $display("FAIL pause_hold got %0d held=%0d want 5 held=1", dem8_bit, held);
                end else $display("pause_hold %0d for 40 clk", dem8_bit);
                ss = 1'b0;
                // Two clocks of sync on each side of the pause plus the two
                // prescaler states still left in the frozen phase.
                push_step(8'd6, 4);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                wait_change(got, n);
                vectors++;
                if (got !== e.val || n != e.gap) begin
                    miscompares++;
                    $display("FAIL pause got %0d after %0d clk want %0d after %0d clk", got, n, e.val, e.gap);
                end else $display("pause %0d after %0d clk", got, n);
            end
        end
    endtask

    task automatic test_dir_flip();
        exp_t       e;
        logic [7:0] got;
        int         n;
        push_step(8'd7, 4); push_step(8'd8, 4); push_step(8'd9, 4);
        push_step(8'd10, 4);
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) begin
                @(negedge clk50m);
                ud = 1'b0;
                push_step(8'd9, 3);
                push_step(8'd8, 4);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                wait_change(got, n);
                vectors++;
                if (got !== e.val || n != e.gap) begin
                    miscompares++;
                    $display("FAIL dir_flip got %0d after %0d clk want %0d after %0d clk", got, n, e.val, e.gap);
                end else $display("dir_flip %0d after %0d clk", got, n);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t       e;
        logic [7:0] got;
        int         n;
        ud = 1'b1;
        for (int v = 9; v <= 77; v++) push_step(8'(v), 4);
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) begin
                // Pulse reset between clock edges: the clear must not wait for a clock.
                #3 rs = 1'b0;
                #1;
                vectors++;
                if (dem8_bit !== 8'd0) begin
                    miscompares++;
                    $display("FAIL reset_async got %0d want 0", dem8_bit);
                end else $display("reset_async %0d", dem8_bit);
                @(negedge clk50m);
                rs = 1'b1;
                push_step(8'd1, 6);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                wait_change(got, n);
                vectors++;
                if (got !== e.val || n != e.gap) begin
                    miscompares++;
                    $display("FAIL reset_mid got %0d after %0d clk want %0d after %0d clk", got, n, e.val, e.gap);
                end else if (e.val == 8'd1 || e.val == 8'd77) begin
                    $display("reset_mid %0d after %0d clk", got, n);
                end
            end
        end
    endtask

    task automatic test_ss_glitch();
        exp_t       e;
        logic [7:0] got;
        int         n;
        // The pulse sits wholly between two rising edges.
        #2 ss = 1'b1;
        #6 ss = 1'b0;
        push_step(8'd2, 4);
        push_step(8'd3, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_change(got, n);
            vectors++;
            if (got !== e.val || n != e.gap) begin
                miscompares++;
                $display("FAIL ss_glitch got %0d after %0d clk want %0d after %0d clk", got, n, e.val, e.gap);
            end else $display("ss_glitch %0d after %0d clk", got, n);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_pause();
        test_dir_flip();
        test_reset_mid();
        test_ss_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
